// File: rtl/uart_rx_ovs.sv
// UART receiver with 16x oversampling, selectable baud and a one-entry valid/ready output.
// Define UART_RX_PARITY_EN to expect and check an even parity bit between data and stop.
module uart_rx_ovs #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OVS    = 16,
  parameter int unsigned DIV_0  = 651,
  parameter int unsigned DIV_1  = 326,
  parameter int unsigned DIV_2  = 163,
  parameter int unsigned DIV_3  = 54
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        sel,
  input  logic              rx_in,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data_out,
  output logic              rx_valid,
  output logic              parity_bit_error,
  output logic              stop_bit_error,
  output logic              overrun_error,
  output logic              rx_busy
);

  localparam int unsigned OW = $clog2(OVS);
  localparam int unsigned BW = $clog2(DATA_W);
  localparam logic [OW-1:0] OvsLast = OW'(OVS - 1);
  localparam logic [OW-1:0] OvsMid  = OW'(OVS / 2 - 1);
  localparam logic [BW-1:0] BitLast = BW'(DATA_W - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StBreak  = 3'd5;

  logic              rx_s1_q, rx_s2_q;
  logic [2:0]        state_q, state_d;
  logic [15:0]       tick_cnt_q, tick_cnt_d;
  logic [15:0]       div_q, div_d, div_sel;
  logic [OW-1:0]     ovs_q, ovs_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              serr_frame_q, serr_frame_d;
  logic              commit_q, commit_d;
  logic              tick;
  logic              rx_sync;

  logic [DATA_W-1:0] data_q;
  logic              valid_q, serr_q, ovr_q;

  assign rx_sync = rx_s2_q;
  assign tick    = (state_q != StIdle) && (tick_cnt_q == div_q - 16'd1);

  always_comb begin
    div_sel = 16'(DIV_3);
    case (sel)
      2'b00:   div_sel = 16'(DIV_0);
      2'b01:   div_sel = 16'(DIV_1);
      2'b10:   div_sel = 16'(DIV_2);
      default: div_sel = 16'(DIV_3);
    endcase
  end

  // Tick divider idles at zero so every frame starts from a fresh bit phase.
  assign tick_cnt_d = ((state_q == StIdle) || tick) ? 16'd0 : tick_cnt_q + 16'd1;

`ifdef UART_RX_PARITY_EN
  logic perr_frame_q, perr_frame_d;
  logic perr_q;
`endif

  always_comb begin
    state_d      = state_q;
    ovs_d        = ovs_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    div_d        = div_q;
    serr_frame_d = serr_frame_q;
    commit_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_frame_d = perr_frame_q;
`endif
    case (state_q)
      StIdle: begin
        if (!rx_sync) begin
          state_d = StStart;
          ovs_d   = '0;
          bit_d   = '0;
          div_d   = div_sel;
        end
      end
      StStart: begin
        if (tick) begin
          if (ovs_q == OvsMid) begin
            ovs_d   = '0;
            state_d = rx_sync ? StIdle : StData;
          end else begin
            ovs_d = ovs_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (ovs_q == OvsLast) begin
            ovs_d   = '0;
            shift_d = {rx_sync, shift_q[DATA_W-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end else begin
            ovs_d = ovs_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          if (ovs_q == OvsLast) begin
            ovs_d        = '0;
            perr_frame_d = ^{shift_q, rx_sync};
            state_d      = StStop;
          end else begin
            ovs_d = ovs_q + 1'b1;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (ovs_q == OvsLast) begin
            ovs_d        = '0;
            commit_d     = 1'b1;
            serr_frame_d = ~rx_sync;
            state_d      = rx_sync ? StIdle : StBreak;
          end else begin
            ovs_d = ovs_q + 1'b1;
          end
        end
      end
      StBreak: begin
        // A held-low line must not be mistaken for a new start bit.
        if (rx_sync) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      state_q      <= StIdle;
      tick_cnt_q   <= '0;
      div_q        <= '0;
      ovs_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      serr_frame_q <= 1'b0;
      commit_q     <= 1'b0;
    end else begin
      rx_s1_q      <= rx_in;
      rx_s2_q      <= rx_s1_q;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      div_q        <= div_d;
      ovs_q        <= ovs_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      serr_frame_q <= serr_frame_d;
      commit_q     <= commit_d;
    end
  end

  // Holding register: a commit wins over a same-cycle handshake, otherwise it is an overrun.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      serr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (commit_q) begin
        if (!valid_q || rx_ready) begin
          data_q  <= shift_q;
          serr_q  <= serr_frame_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perr_frame_q <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      perr_frame_q <= perr_frame_d;
      if (commit_q && (!valid_q || rx_ready)) perr_q <= perr_frame_q;
    end
  end
  assign parity_bit_error = perr_q;
`else
  assign parity_bit_error = 1'b0;
`endif

  assign rx_data_out    = data_q;
  assign rx_valid       = valid_q;
  assign stop_bit_error = serr_q;
  assign overrun_error  = ovr_q;
  assign rx_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Scoreboard bench for uart_rx_ovs at sel=2'b11 (864 clk per bit).
module tb_uart_rx_ovs;

  localparam int BIT = 864;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] sel;
  logic       rx_in;
  logic       rx_ready;
  logic [7:0] rx_data_out;
  logic       rx_valid, parity_bit_error, stop_bit_error, overrun_error, rx_busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       serr;
  } frame_t;

  frame_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int ovr_cnt = 0;

  uart_rx_ovs dut (
    .clk              (clk),
    .rstn             (rstn),
    .sel              (sel),
    .rx_in            (rx_in),
    .rx_ready         (rx_ready),
    .rx_data_out      (rx_data_out),
    .rx_valid         (rx_valid),
    .parity_bit_error (parity_bit_error),
    .stop_bit_error   (stop_bit_error),
    .overrun_error    (overrun_error),
    .rx_busy          (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Consumer side: every accepted word must match the oldest expected frame.
  always @(negedge clk) begin
    if (rstn && rx_valid && rx_ready) begin
      check_val("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        frame_t e;
        e = sb.pop_front();
        check_val("data", 32'(rx_data_out), 32'(e.data));
        check_val("parity_err", 32'(parity_bit_error), 32'(e.perr));
        check_val("stop_err", 32'(stop_bit_error), 32'(e.serr));
      end
    end
    if (overrun_error) ovr_cnt++;
  end

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_val,
                            input logic expect_out);
    frame_t e;
    e.data = d;
`ifdef UART_RX_PARITY_EN
    e.perr = par_flip;
`else
    e.perr = 1'b0;
`endif
    e.serr = ~stop_val;
    if (expect_out) sb.push_back(e);
    rx_in = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      cyc(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rx_in = (^d) ^ par_flip;
    cyc(BIT);
`endif
    rx_in = stop_val;
    cyc(BIT);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      cyc(1);
      n++;
    end
    check_val(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(rx_valid), 32'd0);
    check_val({tag, "_busy"}, 32'(rx_busy), 32'd0);
    check_val({tag, "_data"}, 32'(rx_data_out), 32'd0);
    check_val({tag, "_flags"}, 32'({parity_bit_error, stop_bit_error, overrun_error}), 32'd0);
  endtask

  initial begin
    repeat (99000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; sel = 2'b11; rx_in = 1'b1; rx_ready = 1'b1;
    cyc(3);
    check_idle_outputs("reset");
    rstn = 1'b1;
    cyc(20);

    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    wait_drain("drain_a5");
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    wait_drain("drain_3c");

    // Stop bit low, line held low two more bits: flagged frame, then break handling.
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    cyc(BIT);
    check_val("break_busy", 32'(rx_busy), 32'd1);
    cyc(BIT);
    rx_in = 1'b1;
    cyc(8);
    check_val("break_done", 32'(rx_busy), 32'd0);
    wait_drain("drain_55");

    // sel changed mid-frame must be ignored until the next start bit.
    fork
      send_frame(8'h0F, 1'b0, 1'b1, 1'b1);
      begin
        cyc(2 * BIT);
        sel = 2'b00;
      end
    join
    sel = 2'b11;
    wait_drain("drain_0f");

    rx_in = 1'b0;
    cyc(216);
    rx_in = 1'b1;
    cyc(BIT);
    check_val("glitch_busy", 32'(rx_busy), 32'd0);
    check_val("glitch_valid", 32'(rx_valid), 32'd0);

    rx_ready = 1'b0;
    ovr_cnt = 0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    check_val("ovr_pulses", 32'(ovr_cnt), 32'd1);
    check_val("ovr_valid", 32'(rx_valid), 32'd1);
    check_val("ovr_data", 32'(rx_data_out), 32'h11);
    rx_ready = 1'b1;
    cyc(2);
    check_val("ovr_release", 32'(rx_valid), 32'd0);
    wait_drain("drain_11");

    // Reset in the middle of data bit 3 of 0x77.
    rx_in = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 3; i++) begin
      rx_in = 1'b1;
      cyc(BIT);
    end
    rx_in = 1'b0;
    cyc(BIT / 2);
    check_val("pre_rst_busy", 32'(rx_busy), 32'd1);
    rstn = 1'b0;
    cyc(1);
    check_idle_outputs("midrst");
    cyc(1);
    rstn = 1'b1;
    rx_in = 1'b1;
    cyc(BIT);
    check_val("post_rst_valid", 32'(rx_valid), 32'd0);

    send_frame(8'h81, 1'b0, 1'b1, 1'b1);
    wait_drain("drain_81");
    cyc(BIT);
    check_val("final_valid", 32'(rx_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
